lfsr_prbs_engine: RTL

Sequential PRBS generator plus self-synchronising PRBS checker, built on the team's parallel Fibonacci LFSR step. It advances DATA_WIDTH bits per accepted word. The generator drives test patterns into links and serialisers. The checker hunts for lock on a received stream, tracks lock/loss, and keeps saturating bit-error and word-error counters for link bring-up.

---
 rtl/lfsr_prbs_engine_if.sv | 51 +++++
 rtl/lfsr_prbs_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_engine_if.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_engine_if
// Bundles the generator handshake and the checker stream/status signals of
// lfsr_prbs_engine so they can be passed around as one port.
//
// Signals:
//   gen_seed       generator seed value
//   gen_seed_load  load gen_seed into the generator state
//   gen_data       generated word (MSB-first bit order)
//   gen_valid      gen_data valid
//   gen_ready      downstream accepts gen_data
//   chk_data       received word
//   chk_valid      chk_data valid (always accepted)
//   chk_locked     checker is locked to the incoming stream
//   chk_err        one-cycle pulse for an errored word while locked
//   chk_bit_errs   saturating errored-bit count
//   chk_word_errs  saturating errored-word count
//   cnt_clear      synchronous clear of both error counters
//
// Modports:
//   slave   the engine side
//   master  the side that drives the engine (link model, testbench)
// -----------------------------------------------------------------------------
interface lfsr_prbs_engine_if #(
    parameter int LFSR_WIDTH = 31,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
);
    logic [LFSR_WIDTH-1:0] gen_seed;
    logic                  gen_seed_load;
    logic [DATA_WIDTH-1:0] gen_data;
    logic                  gen_valid;
    logic                  gen_ready;
    logic [DATA_WIDTH-1:0] chk_data;
    logic                  chk_valid;
    logic                  chk_locked;
    logic                  chk_err;
    logic [CNT_WIDTH-1:0]  chk_bit_errs;
    logic [CNT_WIDTH-1:0]  chk_word_errs;
    logic                  cnt_clear;

    modport slave (
        input  gen_seed, gen_seed_load, gen_ready, chk_data, chk_valid, cnt_clear,
        output gen_data, gen_valid, chk_locked, chk_err, chk_bit_errs, chk_word_errs
    );

    modport master (
        output gen_seed, gen_seed_load, gen_ready, chk_data, chk_valid, cnt_clear,
        input  gen_data, gen_valid, chk_locked, chk_err, chk_bit_errs, chk_word_errs
    );
endinterface

// File: rtl/lfsr_prbs_engine.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_engine
// PRBS generator plus self-synchronising PRBS checker built on a parallel
// Fibonacci LFSR step that advances DATA_WIDTH bits per word.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    lfsr_prbs_engine_if.slave
//            generator: gen_seed, gen_seed_load, gen_data, gen_valid, gen_ready
//            checker:   chk_data, chk_valid, chk_locked, chk_err,
//                       chk_bit_errs, chk_word_errs, cnt_clear
// -----------------------------------------------------------------------------
module lfsr_prbs_engine #(
    parameter int                    LFSR_WIDTH    = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    LOCK_THRESH   = 16,
    parameter int                    UNLOCK_THRESH = 4,
    parameter int                    CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_prbs_engine_if.slave    bus
);

    // Bit 0 of the polynomial has no meaning; bit j taps state[j-1].
    localparam logic [LFSR_WIDTH-2:0] TAPS = LFSR_POLY[LFSR_WIDTH-1:1];
    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int BAD_W  = $clog2(UNLOCK_THRESH + 1);
    // Wide enough that counter max plus a 64-bit popcount cannot wrap.
    localparam int SUM_W  = CNT_WIDTH + 8;

    typedef enum logic {HUNT, LOCKED} chk_fsm_t;

    // One word step. Returns {next_state, word}. With feed_fwd set the
    // received bit is shifted in instead of the feedback bit, which is how
    // the checker pulls its state onto an unknown-phase stream.
    function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] lfsr_step(
        input logic [LFSR_WIDTH-1:0] state,
        input logic [DATA_WIDTH-1:0] rx,
        input logic                  feed_fwd
    );
        logic [LFSR_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] w;
        logic                  fb;
        s = state;
        w = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & TAPS));
            w[DATA_WIDTH-1-i] = fb;
            s = {s[LFSR_WIDTH-2:0], (feed_fwd ? rx[DATA_WIDTH-1-i] : fb)};
        end
        return {s, w};
    endfunction

    function automatic logic [7:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    // ---------------------------------------------------------------- generator
    logic [LFSR_WIDTH-1:0] gen_state;
    logic [LFSR_WIDTH-1:0] gen_state_next;
    logic [DATA_WIDTH-1:0] gen_word_next;
    logic [DATA_WIDTH-1:0] gen_data_q;
    logic                  gen_valid_q;

    always_comb begin
        {gen_state_next, gen_word_next} = lfsr_step(gen_state, '0, 1'b0);
    end

    // Registered output word; a new word loads whenever the slot is empty or
    // the current word is being accepted, so throughput is one word/cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state   <= '1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
        end else if (bus.gen_seed_load) begin
            gen_state   <= bus.gen_seed;
            gen_valid_q <= 1'b0;
        end else if (!gen_valid_q || bus.gen_ready) begin
            gen_state   <= gen_state_next;
            gen_data_q  <= gen_word_next;
            gen_valid_q <= 1'b1;
        end
    end

    assign bus.gen_data  = gen_data_q;
    assign bus.gen_valid = gen_valid_q;

    // ------------------------------------------------------------------ checker
    chk_fsm_t              fsm, fsm_next;
    logic [LFSR_WIDTH-1:0] chk_state, chk_state_next;
    logic [GOOD_W-1:0]     good_cnt, good_next, good_inc;
    logic [BAD_W-1:0]      bad_cnt, bad_next, bad_inc;
    logic                  err_q, err_next;
    logic [CNT_WIDTH-1:0]  bit_errs, bit_next;
    logic [CNT_WIDTH-1:0]  word_errs, word_next;
    logic [LFSR_WIDTH-1:0] exp_state, ff_state;
    logic [DATA_WIDTH-1:0] exp_word, ff_word_unused;
    logic [DATA_WIDTH-1:0] mism;
    logic [SUM_W-1:0]      bit_sum;

    always_comb begin
        {exp_state, exp_word}      = lfsr_step(chk_state, '0, 1'b0);
        {ff_state, ff_word_unused} = lfsr_step(chk_state, bus.chk_data, 1'b1);
        mism     = bus.chk_data ^ exp_word;
        good_inc = good_cnt + GOOD_W'(1);
        bad_inc  = bad_cnt + BAD_W'(1);
        bit_sum  = SUM_W'(bit_errs) + SUM_W'(popcount(mism));
    end

    // Next-state logic. Nothing moves on a bubble except the chk_err pulse,
    // which always falls back to 0.
    always_comb begin
        fsm_next       = fsm;
        chk_state_next = chk_state;
        good_next      = good_cnt;
        bad_next       = bad_cnt;
        err_next       = 1'b0;
        bit_next       = bit_errs;
        word_next      = word_errs;

        if (bus.chk_valid) begin
            case (fsm)
                HUNT: begin
                    chk_state_next = ff_state;
                    if (mism == '0) begin
                        good_next = good_inc;
                        if (good_inc == GOOD_W'(LOCK_THRESH)) begin
                            fsm_next = LOCKED;
                            bad_next = '0;
                        end
                    end else begin
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    chk_state_next = exp_state;
                    if (mism != '0) begin
                        err_next = 1'b1;
                        bit_next = (|bit_sum[SUM_W-1:CNT_WIDTH]) ? '1
                                                                 : bit_sum[CNT_WIDTH-1:0];
                        word_next = (&word_errs) ? word_errs : word_errs + CNT_WIDTH'(1);
                        bad_next = bad_inc;
                        if (bad_inc == BAD_W'(UNLOCK_THRESH)) begin
                            fsm_next  = HUNT;
                            good_next = '0;
                        end
                    end else begin
                        bad_next = '0;
                    end
                end
                default: fsm_next = HUNT;
            endcase
        end

        // Clear beats any increment landing in the same cycle.
        if (bus.cnt_clear) begin
            bit_next  = '0;
            word_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= HUNT;
            chk_state <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_q     <= 1'b0;
            bit_errs  <= '0;
            word_errs <= '0;
        end else begin
            fsm       <= fsm_next;
            chk_state <= chk_state_next;
            good_cnt  <= good_next;
            bad_cnt   <= bad_next;
            err_q     <= err_next;
            bit_errs  <= bit_next;
            word_errs <= word_next;
        end
    end

    assign bus.chk_locked    = (fsm == LOCKED);
    assign bus.chk_err       = err_q;
    assign bus.chk_bit_errs  = bit_errs;
    assign bus.chk_word_errs = word_errs;

endmodule
